sdram_arbit: RTL and testbench

SDRAM_ARBIT -- requirements
Module: sdram_arbit

---
 rtl/sdram_arbit.sv | 111 +++++++++++
 tb/tb_sdram_arbit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: owns the SDRAM command/address pins.
// The init sequencer drives them until it reports done. After that, the
// refresh, write and read channels are granted in fixed priority.
module sdram_arbit #(
  parameter logic [3:0] CMD_NOP = 4'b0111
) (
  input  logic        sclk,
  input  logic        s_rst_n,
  // init sequencer
  input  logic        flag_init_end,
  input  logic [3:0]  init_cmd,
  input  logic [11:0] init_addr,
  // auto-refresh channel
  input  logic        ref_req,
  output logic        ref_en,
  input  logic        flag_ref_end,
  input  logic [3:0]  aref_cmd,
  input  logic [11:0] aref_addr,
  // write channel
  input  logic        wr_req,
  output logic        wr_en,
  input  logic        flag_wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [11:0] wr_addr,
  // read channel
  input  logic        rd_req,
  output logic        rd_en,
  input  logic        flag_rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [11:0] rd_addr,
  // SDRAM pins
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_bank,
  output logic [11:0] sdram_addr
);

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    ARBIT = 3'd1,
    AREF  = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] sd_cmd;

  // State register
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) state <= INIT;
    else          state <= state_nxt;
  end

  // Next state: fixed-priority pick in ARBIT, return to ARBIT on the owner's end flag
  always_comb begin
    state_nxt = state;
    unique case (state)
      INIT:  if (flag_init_end) state_nxt = ARBIT;
      ARBIT: begin
        if (ref_req)     state_nxt = AREF;
        else if (wr_req) state_nxt = WRITE;
        else if (rd_req) state_nxt = READ;
      end
      AREF:  if (flag_ref_end) state_nxt = ARBIT;
      WRITE: if (flag_wr_end)  state_nxt = ARBIT;
      READ:  if (flag_rd_end)  state_nxt = ARBIT;
      default: state_nxt = INIT;
    endcase
  end

  // Grant pulses: high only in the first cycle of the granted state
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      ref_en <= 1'b0;
      wr_en  <= 1'b0;
      rd_en  <= 1'b0;
    end else begin
      ref_en <= (state == ARBIT) && (state_nxt == AREF);
      wr_en  <= (state == ARBIT) && (state_nxt == WRITE);
      rd_en  <= (state == ARBIT) && (state_nxt == READ);
    end
  end

  // Clock enable comes up on the first edge after reset release
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) sdram_cke <= 1'b0;
    else          sdram_cke <= 1'b1;
  end

  // Pin mux: the current owner drives command and address, NOP when idle
  always_comb begin
    sd_cmd     = CMD_NOP;
    sdram_addr = '0;
    unique case (state)
      INIT:  begin sd_cmd = init_cmd; sdram_addr = init_addr; end
      AREF:  begin sd_cmd = aref_cmd; sdram_addr = aref_addr; end
      WRITE: begin sd_cmd = wr_cmd;   sdram_addr = wr_addr;   end
      READ:  begin sd_cmd = rd_cmd;   sdram_addr = rd_addr;   end
      default: begin sd_cmd = CMD_NOP; sdram_addr = '0; end
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = sd_cmd;
  assign sdram_bank = '0;

endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: directed scenarios plus randomized traffic, all
// checked against a bus-ownership model of the arbiter.
module tb_sdram_arbit;

  logic        sclk = 1'b0;
  logic        s_rst_n = 1'b0;
  logic        flag_init_end = 1'b0;
  logic [3:0]  init_cmd = 4'b0111;
  logic [11:0] init_addr = '0;
  logic        ref_req = 1'b0, flag_ref_end = 1'b0;
  logic [3:0]  aref_cmd = 4'b0001;
  logic [11:0] aref_addr = '0;
  logic        wr_req = 1'b0, flag_wr_end = 1'b0;
  logic [3:0]  wr_cmd = 4'b0100;
  logic [11:0] wr_addr = '0;
  logic        rd_req = 1'b0, flag_rd_end = 1'b0;
  logic [3:0]  rd_cmd = 4'b0101;
  logic [11:0] rd_addr = '0;
  logic        ref_en, wr_en, rd_en;
  logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_bank;
  logic [11:0] sdram_addr;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  sdram_arbit #(.CMD_NOP(4'b0111)) dut (
    .sclk(sclk), .s_rst_n(s_rst_n),
    .flag_init_end(flag_init_end), .init_cmd(init_cmd), .init_addr(init_addr),
    .ref_req(ref_req), .ref_en(ref_en), .flag_ref_end(flag_ref_end),
    .aref_cmd(aref_cmd), .aref_addr(aref_addr),
    .wr_req(wr_req), .wr_en(wr_en), .flag_wr_end(flag_wr_end),
    .wr_cmd(wr_cmd), .wr_addr(wr_addr),
    .rd_req(rd_req), .rd_en(rd_en), .flag_rd_end(flag_rd_end),
    .rd_cmd(rd_cmd), .rd_addr(rd_addr),
    .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_bank(sdram_bank), .sdram_addr(sdram_addr)
  );

  always #5 sclk = ~sclk;

  wire [3:0] pins = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ownership model: owner -1 = init sequencer, 0 = nobody, 1/2/3 = ref/wr/rd
  int       owner = -1;
  bit [3:1] grant = '0;
  bit       cke_m = 1'b0;

  function automatic bit req_of(input int ch);
    return (ch == 1) ? ref_req : (ch == 2) ? wr_req : rd_req;
  endfunction

  function automatic bit end_of(input int ch);
    return (ch == 1) ? flag_ref_end : (ch == 2) ? flag_wr_end : flag_rd_end;
  endfunction

  always @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      owner <= -1;
      grant <= '0;
      cke_m <= 1'b0;
    end else begin
      automatic int       nxt = owner;
      automatic bit [3:1] g = '0;
      if (owner == -1) begin
        if (flag_init_end) nxt = 0;
      end else if (owner == 0) begin
        for (int ch = 3; ch >= 1; ch--)
          if (req_of(ch)) nxt = ch;
        if (nxt != 0) g[nxt] = 1'b1;
      end else if (end_of(owner)) begin
        nxt = 0;
      end
      owner <= nxt;
      grant <= g;
      cke_m <= 1'b1;
    end
  end

  // Compare process: every cycle, 2 time units after the active edge
  always @(posedge sclk) begin
    #2;
    if (chk_en) begin
      automatic int ecmd;
      automatic int eaddr;
      case (owner)
        -1:      begin ecmd = init_cmd; eaddr = init_addr; end
        1:       begin ecmd = aref_cmd; eaddr = aref_addr; end
        2:       begin ecmd = wr_cmd;   eaddr = wr_addr;   end
        3:       begin ecmd = rd_cmd;   eaddr = rd_addr;   end
        default: begin ecmd = 4'b0111;  eaddr = 0;         end
      endcase
      chk("ref_en", ref_en, grant[1]);
      chk("wr_en", wr_en, grant[2]);
      chk("rd_en", rd_en, grant[3]);
      chk("cmd", pins, ecmd);
      chk("addr", sdram_addr, eaddr);
      chk("cke", sdram_cke, cke_m);
      chk("bank", sdram_bank, 0);
      chk("onehot_en", int'(ref_en) + int'(wr_en) + int'(rd_en) <= 1, 1);
    end
  end

  // One cycle; inputs are changed by the caller afterwards, well clear of the edge
  task automatic tick();
    @(posedge sclk);
    #3;
  endtask

  initial begin
    int wr_pulses;
    // reset, then flag_init_end at cycle 10
    tick();
    chk_en = 1'b1;
    chk("rst_cke", sdram_cke, 0);
    chk("rst_pins_init", pins, 4'b0111);
    s_rst_n = 1'b1;
    for (int i = 1; i < 10; i++) begin
      init_cmd = 4'b0010;
      tick();
    end
    chk("init_pins", pins, 4'b0010);
    chk("init_cke", sdram_cke, 1);
    flag_init_end = 1'b1;
    tick();
    chk("arbit_pins", pins, 4'b0111);
    chk("arbit_addr", sdram_addr, 0);
    chk("arbit_cke", sdram_cke, 1);

    // all three requests together: refresh wins
    ref_req = 1; wr_req = 1; rd_req = 1;
    aref_cmd = 4'b0001; aref_addr = 12'h400;
    tick();
    chk("prio_ref_en", ref_en, 1);
    chk("prio_wr_en", wr_en, 0);
    chk("prio_rd_en", rd_en, 0);
    chk("aref_pins", pins, 4'b0001);
    chk("aref_addr", sdram_addr, 12'h400);
    ref_req = 0; rd_req = 0;
    tick();
    chk("ref_en_1cyc", ref_en, 0);
    flag_ref_end = 1;
    tick();
    flag_ref_end = 0;
    chk("post_ref_nop", pins, 4'b0111);
    chk("post_ref_no_grant", wr_en, 0);
    tick();
    chk("wr_after_ref", wr_en, 1);
    wr_req = 0;

    // refresh requested during WRITE waits for flag_wr_end
    ref_req = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ref_blocked", ref_en, 0);
    end
    flag_wr_end = 1;
    tick();
    flag_wr_end = 0;
    chk("ref_wait_arbit", ref_en, 0);
    tick();
    chk("ref_2cyc_after_end", ref_en, 1);
    ref_req = 0;
    flag_ref_end = 1;
    tick();
    flag_ref_end = 0;

    // READ ignores foreign end flags
    rd_req = 1;
    tick();
    chk("rd_grant", rd_en, 1);
    rd_req = 0;
    flag_wr_end = 1; flag_ref_end = 1; rd_cmd = 4'b0101;
    tick();
    flag_wr_end = 0; flag_ref_end = 0;
    tick();
    chk("rd_hold_pins", pins, 4'b0101);
    chk("rd_hold_no_grant", int'(ref_en | wr_en | rd_en), 0);
    flag_rd_end = 1;
    tick();
    flag_rd_end = 0;

    // wr_req held across three completions
    wr_req = 1;
    wr_pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      wr_pulses += int'(wr_en);
      flag_wr_end = 1;
      tick();
      flag_wr_end = 0;
      chk("wr_gap_nop", pins, 4'b0111);
      chk("wr_gap_en", wr_en, 0);
    end
    chk("wr_pulse_count", wr_pulses, 3);

    // reset mid-WRITE aborts the service
    tick();
    wr_cmd = 4'b0100; init_cmd = 4'b0010;
    tick();
    chk("mid_wr_pins", pins, 4'b0100);
    s_rst_n = 0; flag_init_end = 0;
    #1;
    chk("rst_en", int'(ref_en | wr_en | rd_en), 0);
    chk("rst_cke_async", sdram_cke, 0);
    chk("rst_pins_async", pins, 4'b0010);
    tick();
    s_rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("no_wr_before_init", wr_en, 0);
    end
    flag_init_end = 1;
    tick();
    tick();
    chk("wr_after_reinit", wr_en, 1);
    wr_req = 0;

    // randomized traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      init_cmd = 4'($urandom); init_addr = 12'($urandom);
      aref_cmd = 4'($urandom); aref_addr = 12'($urandom);
      wr_cmd = 4'($urandom);   wr_addr = 12'($urandom);
      rd_cmd = 4'($urandom);   rd_addr = 12'($urandom);
      if (ref_en) ref_req = 0; else if ($urandom_range(7) == 0) ref_req = 1;
      if (wr_en)  wr_req = 0;  else if ($urandom_range(3) == 0) wr_req = 1;
      if (rd_en)  rd_req = 0;  else if ($urandom_range(3) == 0) rd_req = 1;
      flag_ref_end = ($urandom_range(4) == 0);
      flag_wr_end  = ($urandom_range(4) == 0);
      flag_rd_end  = ($urandom_range(4) == 0);
      if (!s_rst_n) s_rst_n = 1;
      else if ($urandom_range(499) == 0) begin s_rst_n = 0; flag_init_end = 0; end
      if (!flag_init_end && $urandom_range(5) == 0) flag_init_end = 1;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
